cpu4_alu_arb: RTL and testbench

Two-port arbiter and sequencer that shares the single cpu4 ALU between two requesters, such as the execute stage on port 0 and the branch-compare unit on port 1. It accepts one operation at a time over a valid/ready handshake and picks between simultaneous requests round-robin. It drives the ALU from registered operands, captures the ALU result and zero flag, and returns them to the granted requester over a response handshake. It sits between the requesters and an external combinational ALU instance (add = 3'b000, sub = 3'b001).

---
 rtl/cpu4_alu_arb.sv | 138 +++++++++++++
 tb/tb_cpu4_alu_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu4_alu_arb.sv
// Shares one external combinational cpu4 ALU between two requesters.
// Round-robin grant, registered operands, and a held response until the owner accepts it.
module cpu4_alu_arb (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [2:0]  req0_control_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [2:0]  req1_control_i,
  output logic [1:0]  resp_valid_o,
  input  logic [1:0]  resp_ready_i,
  output logic [31:0] resp_y_o,
  output logic        resp_zero_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [2:0]  alu_control_o,
  input  logic [31:0] alu_y_i,
  input  logic        alu_zero_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [31:0] resp_y_q, resp_y_d;
  logic        resp_zero_q, resp_zero_d;
  logic [1:0]  resp_valid_q, resp_valid_d;
  logic        busy_q, busy_d;

  logic        grant;
  logic        any_req;
  logic        resp_accept;

  // The priority pointer only matters when both ports ask at once.
  assign any_req     = |req_valid_i;
  assign grant       = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];
  assign resp_accept = resp_ready_i[owner_q];

  always_comb begin
    req_ready_o = 2'b00;
    if ((state_q == ST_IDLE) && !reset_i && any_req) begin
      req_ready_o = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    ctl_d        = ctl_q;
    resp_y_d     = resp_y_q;
    resp_zero_d  = resp_zero_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = grant;
          opa_d   = grant ? req1_a_i       : req0_a_i;
          opb_d   = grant ? req1_b_i       : req0_b_i;
          ctl_d   = grant ? req1_control_i : req0_control_i;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_y_d     = alu_y_i;
        resp_zero_d  = alu_zero_i;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_accept) begin
          resp_valid_d = 2'b00;
          busy_d       = 1'b0;
          prio_d       = ~owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d = 2'b00;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      ctl_q        <= 3'd0;
      resp_y_q     <= 32'd0;
      resp_zero_q  <= 1'b0;
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      ctl_q        <= ctl_d;
      resp_y_q     <= resp_y_d;
      resp_zero_q  <= resp_zero_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Operand registers feed the ALU directly, so it holds its inputs outside EXEC.
  assign alu_a_o       = opa_q;
  assign alu_b_o       = opb_q;
  assign alu_control_o = ctl_q;
  assign resp_y_o      = resp_y_q;
  assign resp_zero_o   = resp_zero_q;
  assign resp_valid_o  = resp_valid_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_cpu4_alu_arb.sv
// Bench for cpu4_alu_arb: table of single operations plus contention, back-pressure and reset sequences.
module tb_cpu4_alu_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_control, req1_control;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_y;
  logic        resp_zero;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        busy;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [31:0] y;
    logic        z;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] y;
    logic        z;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu4_alu_arb dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_control_i(req0_control),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_control_i(req1_control),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_y_o(resp_y), .resp_zero_o(resp_zero),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_control_o(alu_control),
    .alu_y_i(alu_y), .alu_zero_i(alu_zero),
    .busy_o(busy)
  );

  // Stand-in for the external cpu4 ALU.
  always_comb begin
    alu_y    = 32'd0;
    alu_zero = 1'b0;
    if (alu_control == 3'b000) begin
      alu_y    = alu_a + alu_b;
      alu_zero = (alu_y == 32'd0);
    end else if (alu_control == 3'b001) begin
      alu_y    = alu_a - alu_b;
      alu_zero = (alu_y == 32'd0);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctl);
    if (port) begin
      req1_a = a; req1_b = b; req1_control = ctl;
    end else begin
      req0_a = a; req0_b = b; req0_control = ctl;
    end
    req_valid[port] = 1'b1;
  endtask

  task automatic wait_ready(input logic port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[port]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Response scoreboard and per-cycle invariants.
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_not_both", (req_ready == 2'b11), 0);
      check("ready_while_busy", (busy && (req_ready != 2'b00)), 0);
      check("resp_valid_not_both", (resp_valid == 2'b11), 0);
      if ((resp_valid & resp_ready) != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_port", resp_valid[1], e.port);
          check("resp_y", resp_y, e.y);
          check("resp_zero", resp_zero, e.z);
        end
      end
    end
  end

  initial begin
    bit ok;
    logic grants[3];
    int   ng;

    vecs[0] = '{1'b0, 32'd5,          32'd7, 3'b000, 32'd12,         1'b0};
    vecs[1] = '{1'b1, 32'd9,          32'd9, 3'b001, 32'd0,          1'b1};
    vecs[2] = '{1'b1, 32'd0,          32'd1, 3'b001, 32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1, 3'b000, 32'd0,          1'b1};
    vecs[4] = '{1'b1, 32'd3,          32'd4, 3'b111, 32'd0,          1'b0};
    vecs[5] = '{1'b0, 32'd100,        32'd58, 3'b001, 32'd42,        1'b0};

    reset = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    req0_a = '0; req0_b = '0; req0_control = '0;
    req1_a = '0; req1_b = '0; req1_control = '0;

    #13;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_y", resp_y, 32'd0);
    check("rst_alu_control", alu_control, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      set_req(vecs[k].port, vecs[k].a, vecs[k].b, vecs[k].ctl);
      wait_ready(vecs[k].port, ok);
      if (ok) begin
        check("hs_req_ready", req_ready, vecs[k].port ? 2'b10 : 2'b01);
        sb_q.push_back('{vecs[k].port, vecs[k].y, vecs[k].z});
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("exec_alu_a", alu_a, vecs[k].a);
      check("exec_alu_b", alu_b, vecs[k].b);
      check("exec_alu_control", alu_control, vecs[k].ctl);
      check("exec_busy", busy, 1);
      check("exec_no_resp", resp_valid, 2'b00);
      @(negedge clk);
      check("resp_valid_bit", resp_valid, vecs[k].port ? 2'b10 : 2'b01);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_resp_valid", resp_valid, 2'b00);
      check("hold_alu_a", alu_a, vecs[k].a);
    end
    drain();

    // Contention: both ports held, grants must alternate starting at port 0.
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 32'd10, 32'd3, 3'b000);
    set_req(1'b1, 32'd20, 32'd20, 3'b001);
    ng = 0;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready[1];
        if (req_ready[1]) sb_q.push_back('{1'b1, 32'd0, 1'b1});
        else              sb_q.push_back('{1'b0, 32'd13, 1'b0});
        ng++;
      end
    end
    check("contention_grants", ng, 3);
    if (ng == 3) begin
      check("grant_0", grants[0], 0);
      check("grant_1", grants[1], 1);
      check("grant_2", grants[2], 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Back-pressure: owner withholds resp_ready, non-owner ready is ignored.
    do_reset();
    @(posedge clk); #1;
    set_req(1'b0, 32'd1, 32'd2, 3'b000);
    wait_ready(1'b0, ok);
    if (ok) sb_q.push_back('{1'b0, 32'd3, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    resp_ready = 2'b10;
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1'b1, 32'd7, 32'd2, 3'b001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 2'b01);
      check("bp_resp_y", resp_y, 32'd3);
      check("bp_busy", busy, 1);
      check("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    @(negedge clk);
    check("bp_accept_cycle", resp_valid, 2'b01);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_next_grant", req_ready, 2'b10);
    if (req_ready == 2'b10) sb_q.push_back('{1'b1, 32'd5, 1'b0});
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Reset during EXEC drops the transaction.
    @(posedge clk); #1;
    set_req(1'b0, 32'd5, 32'd5, 3'b000);
    wait_ready(1'b0, ok);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    check("mid_rst_resp_valid", resp_valid, 2'b00);
    check("mid_rst_resp_y", resp_y, 32'd0);
    check("mid_rst_alu_control", alu_control, 3'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dropped_no_resp", resp_valid, 2'b00);
    end
    check("final_queue_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
